// File: rtl/adc7478_ctrl_pkg.sv
// Shared definitions for the AD7478 serial ADC controller.
//   state_e      : controller states (IDLE, CONV, QUIET)
//   FRAME_SCLKS  : SCLK periods per conversion frame
//   DB7_SAMPLE   : capture index (1-based) that carries DB7
//   DB0_SAMPLE   : capture index (1-based) that carries DB0
//   DATA_W       : width of the converted sample
package adc7478_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_QUIET = 2'd2
  } state_e;

  localparam int FRAME_SCLKS = 16;
  localparam int DB7_SAMPLE  = 4;
  localparam int DB0_SAMPLE  = 11;
  localparam int DATA_W      = 8;

  // Two clk_in edges per SCLK period.
  localparam int CONV_EDGES  = 2 * FRAME_SCLKS;
  localparam int CNT_W       = $clog2(CONV_EDGES + 1);

  // Capture register shifts left, so sample k ends up at bit FRAME_SCLKS-k.
  localparam int DB7_BIT     = FRAME_SCLKS - DB7_SAMPLE;
  localparam int DB0_BIT     = FRAME_SCLKS - DB0_SAMPLE;

endpackage

// File: rtl/adc7478_ctrl.sv
// AD7478 serial ADC controller.
// Runs one 16-SCLK conversion frame per request and returns DB7..DB0.
// Ports:
//   clk_in : system clock, all outputs registered on its rising edge
//   reset  : synchronous active-high reset
//   start  : level conversion request, examined only in IDLE
//   cs     : ADC chip select, active low
//   clk    : ADC serial clock (SCLK), idles high
//   so     : ADC serial data (SDATA)
//   eoc    : one-cycle end-of-conversion strobe, data valid when high
//   data   : last converted sample, MSB = DB7
module adc7478_ctrl
  import adc7478_ctrl_pkg::*;
#(
  parameter int QUIET_CYCLES = 2
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  output logic              cs,
  output logic              clk,
  input  logic              so,
  output logic              eoc,
  output logic [DATA_W-1:0] data
);

  localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  state_e                 state_q;
  logic                   cs_q;
  logic                   clk_q;
  logic                   eoc_q;
  logic [DATA_W-1:0]      data_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [QW-1:0]          qcnt_q;
  logic [FRAME_SCLKS-1:0] shreg_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cs_q    <= 1'b1;
      clk_q   <= 1'b1;
      eoc_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      qcnt_q  <= '0;
      shreg_q <= '0;
    end else begin
      eoc_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cs_q  <= 1'b1;
          clk_q <= 1'b1;
          if (start) begin
            cs_q    <= 1'b0;
            cnt_q   <= '0;
            shreg_q <= '0;
            state_q <= ST_CONV;
          end
        end

        ST_CONV: begin
          if (cnt_q == CNT_W'(CONV_EDGES)) begin
            cs_q    <= 1'b1;
            clk_q   <= 1'b1;
            data_q  <= shreg_q[DB7_BIT:DB0_BIT];
            eoc_q   <= 1'b1;
            qcnt_q  <= '0;
            state_q <= ST_QUIET;
          end else begin
            clk_q <= ~clk_q;
            cnt_q <= cnt_q + 1'b1;
            // cnt_q odd means this is an even edge: SCLK rises, sample so.
            if (cnt_q[0]) begin
              shreg_q <= {shreg_q[FRAME_SCLKS-2:0], so};
            end
          end
        end

        ST_QUIET: begin
          if (qcnt_q == QW'(QUIET_CYCLES - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            qcnt_q <= qcnt_q + 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cs   = cs_q;
  assign clk  = clk_q;
  assign eoc  = eoc_q;
  assign data = data_q;

endmodule

// File: tb/tb_adc7478_ctrl.sv
// Self-checking bench for adc7478_ctrl with a behavioural ADC responder
// and a timeline model of the expected controller outputs.
module tb_adc7478_ctrl;

  localparam int QC = 2;

  logic       clk_in;
  logic       reset;
  logic       start;
  logic       cs;
  logic       sclk;
  logic       so;
  logic       eoc;
  logic [7:0] data;

  adc7478_ctrl #(.QUIET_CYCLES(QC)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .start  (start),
    .cs     (cs),
    .clk    (sclk),
    .so     (so),
    .eoc    (eoc),
    .data   (data)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Frame word the ADC will send: bit 15 is frame bit 1.
  logic [15:0] frame;

  // ADC responder: frame bit 1 on cs fall, next bit on each SCLK fall.
  logic [15:0] adc_word;
  int          bitn;
  initial so = 1'b0;
  always @(negedge cs) begin
    adc_word = frame;
    bitn     = 1;
    #1 so = adc_word[15];
  end
  always @(negedge sclk) begin
    if (cs === 1'b0) begin
      bitn++;
      #1 so = (bitn <= 16) ? adc_word[16 - bitn] : adc_word[0];
    end
  end

  // Timeline model: m_t = clk_in edges since the edge that accepted start
  // (-1 when idle). Outputs follow directly from where in the frame we are.
  int          cyc = 0;
  int          m_t = -1;
  logic [7:0]  m_data = 8'h00;
  logic [15:0] m_word = 16'h0;
  bit          m_valid = 1'b0;

  always @(posedge clk_in) begin
    cyc++;
    if (reset) begin
      m_t     = -1;
      m_data  = 8'h00;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_t < 0) begin
        if (start) begin
          m_t    = 0;
          m_word = frame;
        end
      end else begin
        m_t++;
        if (m_t == 33) m_data = m_word[11:4];
        else if (m_t == 33 + QC) m_t = -1;
      end
    end
  end

  // Monitors and per-cycle compare.
  int eoc_cnt = 0, eoc_cyc = 0, cs_low_cnt = 0, clk_fall = 0, cs_fall = 0;
  int hi_run = 0, min_hi = 1000;
  int eoc_q[$];
  logic prev_cs = 1'b1, prev_clk = 1'b1;

  always @(negedge sclk) if (cs === 1'b0) clk_fall++;

  always @(negedge clk_in) begin
    if (m_valid) begin
      check("cs",   {31'd0, cs},   {31'd0, !(m_t >= 0 && m_t <= 32)});
      check("sclk", {31'd0, sclk}, {31'd0, !(m_t >= 1 && m_t <= 32 && (m_t % 2 == 1))});
      check("eoc",  {31'd0, eoc},  {31'd0, m_t == 33});
      check("data", {24'd0, data}, {24'd0, m_data});
      if (cs === 1'b1 && prev_cs === 1'b1)
        check("sclk_still_while_cs_high", {31'd0, sclk}, {31'd0, prev_clk});
      if (eoc === 1'b1) begin
        eoc_cnt++;
        eoc_cyc = cyc;
        eoc_q.push_back(cyc);
      end
      if (cs === 1'b0) begin
        cs_low_cnt++;
        if (prev_cs === 1'b1) begin
          cs_fall++;
          if (hi_run < min_hi) min_hi = hi_run;
        end
        hi_run = 0;
      end else begin
        hi_run++;
      end
      prev_cs  = cs;
      prev_clk = sclk;
    end
  end

  task automatic clear_counts();
    eoc_cnt = 0; cs_low_cnt = 0; clk_fall = 0; cs_fall = 0;
    min_hi = 1000; eoc_q.delete();
  endtask

  task automatic one_conversion(input logic [15:0] f, input logic [7:0] exp, input string name);
    int e0;
    frame = f;
    clear_counts();
    start = 1'b1;
    @(posedge clk_in); #1;
    e0 = cyc;
    start = 1'b0;
    repeat (45) @(posedge clk_in);
    #1;
    check({name, "_data"},    {24'd0, data}, {24'd0, exp});
    check({name, "_eoc_cnt"}, eoc_cnt, 1);
    check({name, "_latency"}, eoc_cyc - e0, 33);
    check({name, "_sclk_pulses"}, clk_fall, 16);
    check({name, "_cs_low"},  cs_low_cnt, 33);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    frame = 16'h0000;
    repeat (3) @(posedge clk_in);
    #1 reset = 1'b0;
    @(negedge clk_in);
    check("rst_cs",   {31'd0, cs},   1);
    check("rst_sclk", {31'd0, sclk}, 1);
    check("rst_eoc",  {31'd0, eoc},  0);
    check("rst_data", {24'd0, data}, 0);
    @(posedge clk_in); #1;

    // Basic conversion and pattern frames with junk in lead/trail bits.
    one_conversion(16'h0A50, 8'hA5, "a5");
    one_conversion(16'hF00F, 8'h00, "zero_ones_pad");
    one_conversion(16'h0FFF, 8'hFF, "ff");
    one_conversion(16'hF3CF, 8'h3C, "3c");

    // Sustained conversions with start held high for 200 cycles.
    clear_counts();
    frame = 16'h0120;
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_in); #1;
      if (m_t == 34) frame = {4'h0, frame[11:4] + 8'h37, 4'h0};
    end
    start = 1'b0;
    repeat (60) @(posedge clk_in);
    #1;
    check("sust_eoc_cnt", eoc_cnt, 6);
    for (int i = 1; i < eoc_q.size(); i++)
      check("sust_period", eoc_q[i] - eoc_q[i-1], 36);
    check("sust_min_cs_high", min_hi, 3);

    // Reset sampled at E10 aborts the frame.
    clear_counts();
    frame = 16'h0C30;
    start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    repeat (9) @(posedge clk_in);
    #1 reset = 1'b1;
    @(posedge clk_in); #1;
    reset = 1'b0;
    @(negedge clk_in);
    check("abort_cs",   {31'd0, cs},   1);
    check("abort_sclk", {31'd0, sclk}, 1);
    check("abort_data", {24'd0, data}, 0);
    repeat (40) @(posedge clk_in);
    #1;
    check("abort_no_eoc", eoc_cnt, 0);
    one_conversion(16'h05A0, 8'h5A, "after_abort");

    // Reset and start on the same edge: reset wins.
    clear_counts();
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk_in); #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk_in);
    check("rst_prio_cs", {31'd0, cs}, 1);

    // No request: nothing moves.
    clear_counts();
    repeat (100) @(posedge clk_in);
    #1;
    check("idle_eoc",   eoc_cnt, 0);
    check("idle_cs",    cs_low_cnt, 0);
    check("idle_sclk",  clk_fall, 0);

    // Start dropped at E5: frame completes once, no second frame.
    clear_counts();
    frame = 16'h0E70;
    start = 1'b1;
    @(posedge clk_in); #1;
    repeat (4) @(posedge clk_in);
    #1 start = 1'b0;
    repeat (80) @(posedge clk_in);
    #1;
    check("drop_eoc_cnt", eoc_cnt, 1);
    check("drop_cs_fall", cs_fall, 1);
    check("drop_data",    {24'd0, data}, {24'd0, 8'hE7});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
